// File: rtl/pipe_elastic.sv
// rtl/pipe_elastic.sv - elastic FIFO pipeline stage with registered ready/valid
// Ready and valid are decoded from the registered occupancy only, so neither handshake side sees a combinational path from the other.
module pipe_elastic #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             IN_READY,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] OUT_DATA,
  input  logic             OUT_READY,
  output logic [CW-1:0]    COUNT
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  // Explicit wrap keeps non-power-of-two depths inside the array.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign IN_READY  = (count != FULL);
  assign OUT_VALID = (count != '0);
  assign COUNT     = count;
  assign push      = IN_VALID && IN_READY && !FLUSH;
  assign pop       = OUT_VALID && OUT_READY && !FLUSH;
  assign OUT_DATA  = OUT_VALID ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (FLUSH) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Storage is deliberately left out of reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= IN_DATA;
    end
  end

endmodule

// File: doc/pipe_elastic.md
PIPE_ELASTIC -- requirements
Module: pipe_elastic

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the entry count; legal range 1..16.
REQ-003 The block SHALL have parameter CW, default $clog2(DEPTH+1), meaning the occupancy counter width.
REQ-004 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 Port FLUSH  input  1  SHALL be the synchronous discard of all held and incoming entries.
REQ-007 Port IN_VALID  input  1  SHALL indicate that the upstream stage presents a payload.
REQ-008 Port IN_DATA  input  WIDTH  SHALL carry the upstream payload.
REQ-009 Port IN_READY  output  1  SHALL indicate that the block accepts a payload this cycle.
REQ-010 Port OUT_VALID  output  1  SHALL indicate that OUT_DATA holds a valid entry.
REQ-011 Port OUT_DATA  output  WIDTH  SHALL carry the oldest held entry.
REQ-012 Port OUT_READY  input  1  SHALL indicate that the downstream stage consumes the entry this cycle.
REQ-013 Port COUNT  output  CW  SHALL report the number of held entries.

Function
REQ-014 Push SHALL occur on an edge where IN_VALID=1, IN_READY=1 and FLUSH=0.
REQ-015 Pop SHALL occur on an edge where OUT_VALID=1, OUT_READY=1 and FLUSH=0.
REQ-016 IN_READY SHALL equal (COUNT != DEPTH) and SHALL depend only on registered state, with no combinational path from OUT_READY.
REQ-017 OUT_VALID SHALL equal (COUNT != 0) and SHALL come from registered state, with no combinational path from IN_VALID.
REQ-018 Entries SHALL leave in strict FIFO order, with no loss and no duplication.
REQ-019 Latency SHALL be 1 cycle: a push into an empty block makes OUT_VALID=1 on the following cycle; there is no same-cycle pass-through.
REQ-020 Simultaneous push and pop SHALL leave COUNT unchanged and advance both read and write pointers.
REQ-021 Push only SHALL increment COUNT; pop only SHALL decrement COUNT.
REQ-022 When full (COUNT=DEPTH), IN_VALID=1 SHALL be held off by IN_READY=0; a pop in that cycle SHALL raise IN_READY on the next cycle.
REQ-023 Read and write pointers SHALL wrap from DEPTH-1 to 0, including for non-power-of-2 DEPTH.
REQ-024 When empty, OUT_DATA SHALL be all zeros.
REQ-025 While OUT_VALID=1 and OUT_READY=0, OUT_DATA SHALL remain stable.
REQ-026 FLUSH=1 SHALL set COUNT=0 and both pointers to 0 on the next edge.
REQ-027 FLUSH=1 SHALL discard any IN_DATA offered in the same cycle and SHALL override a concurrent push or pop.
REQ-028 With DEPTH=1, the block SHALL behave as a single register: IN_READY=!OUT_VALID, and a full block cannot push in the same cycle as a pop.
REQ-029 The storage array SHALL be written only on push; its contents are not reset.

Reset
REQ-030 While rst=0, the block SHALL force COUNT=0, pointers=0, OUT_VALID=0, IN_READY=1 and OUT_DATA=0 immediately, independent of clk.
REQ-031 Reset asserted mid-transfer SHALL discard all held entries, with no partial state surviving.
REQ-032 After rst returns high, the first push SHALL be accepted on the first rising edge.

Verification
REQ-033 Bench SHALL cover: DEPTH=2, push 0xA5A5A5A5 with OUT_READY=0 -> next cycle OUT_VALID=1, OUT_DATA=0xA5A5A5A5, COUNT=1.
REQ-034 Bench SHALL cover: DEPTH=2, push 0x1 and 0x2 with OUT_READY=0 -> COUNT=2, IN_READY=0; offer 0x3 for 3 cycles -> not accepted; then OUT_READY=1 -> outputs 0x1, 0x2, 0x3 in order.
REQ-035 Bench SHALL cover: DEPTH=3, 10 back-to-back pushes with OUT_READY=1 -> pointers wrap, COUNT holds 1 in steady state, 10 outputs match inputs in order.
REQ-036 Bench SHALL cover: COUNT=2 with FLUSH=1 and IN_VALID=1 carrying 0x7 -> next cycle COUNT=0, OUT_VALID=0, and 0x7 never appears at the output.
REQ-037 Bench SHALL cover: COUNT=2, drive rst=0 between clock edges -> OUT_VALID=0, COUNT=0, OUT_DATA=0 before the next edge.
REQ-038 Bench SHALL cover: randomized IN_VALID/OUT_READY for 1000 cycles, DEPTH in {1,2,5} -> scoreboard shows no loss, duplication or reordering, and 0 <= COUNT <= DEPTH throughout.
